// File: rtl/ram_pkg.sv
// Shared definitions for the multi-port RAM with bulk clear: the controller
// state encoding and the default sizing constants.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ctrl_state_e;

  localparam int unsigned DEFAULT_DEPTH = 16;
  // A single-entry array still needs a one-bit pointer.
  localparam int unsigned DEFAULT_INDEX = (DEFAULT_DEPTH > 1) ? $clog2(DEFAULT_DEPTH) : 1;

endpackage

// File: rtl/ram_bypass_mux.sv
// Per-read-port data select: stored entry, optionally overridden by the
// highest-numbered accepted write to the same address in this cycle.
module ram_bypass_mux
  import ram_pkg::*;
#(
  parameter int unsigned INDEX  = DEFAULT_INDEX,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_WR = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [INDEX-1:0]             rd_addr_i,
  input  logic                         rd_valid_i,
  input  logic [WIDTH-1:0]             stored_i,
  input  logic [NUM_WR-1:0]            wr_ok_i,
  input  logic [NUM_WR-1:0][INDEX-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0][WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0]             rd_data_o
);

  // NOTE: combinational logic uses blocking '=' with a default assigned first,
  // so every path drives rd_data_o and no latch is inferred.
  always_comb begin
    rd_data_o = '0;
    if (rd_valid_i) begin
      rd_data_o = stored_i;
      if (BYPASS) begin
        // Ascending scan: a later match overrides, so the highest port wins.
        for (int w = 0; w < int'(NUM_WR); w++) begin
          if (wr_ok_i[w] && (wr_addr_i[w] == rd_addr_i)) begin
            rd_data_o = wr_data_i[w];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ram_multiport_clr.sv
// Multi-port register-file RAM with a sequential bulk-clear sweep, write
// collision flag and optional same-cycle write-to-read forwarding.
module ram_multiport_clr
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned INDEX  = DEFAULT_INDEX,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic [NUM_RD-1:0][INDEX-1:0] rd_addr_i,
  input  logic [NUM_WR-1:0][INDEX-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic [NUM_WR-1:0][WIDTH-1:0] wr_data_i,
  output logic [NUM_RD-1:0][WIDTH-1:0] rd_data_o,
  output logic                         busy_o,
  output logic                         wr_conflict_o
);

  localparam int unsigned     LAST     = DEPTH - 1;
  localparam logic [INDEX-1:0] LAST_PTR = LAST[INDEX-1:0];
  localparam logic [INDEX:0]   DEPTH_L  = DEPTH[INDEX:0];

  ctrl_state_e       state_q, state_d;
  logic [INDEX-1:0]  clr_ptr_q, clr_ptr_d;
  logic              conflict_q, conflict_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [NUM_WR-1:0]            wr_ok;
  logic [NUM_RD-1:0]            rd_ok;
  logic [NUM_RD-1:0][WIDTH-1:0] stored;

  assign busy_o        = (state_q == ST_CLEAR);
  assign wr_conflict_o = conflict_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        // clear_i is not looked at here: a running sweep is never extended.
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int w = 0; w < int'(NUM_WR); w++) begin
      wr_ok[w] = we_i[w] && !busy_o && !clear_i && ({1'b0, wr_addr_i[w]} < DEPTH_L);
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      for (int j = i + 1; j < int'(NUM_WR); j++) begin
        if (wr_ok[i] && wr_ok[j] && (wr_addr_i[i] == wr_addr_i[j])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      conflict_q <= conflict_d;
    end
  end

  // NOTE: the array has no reset branch; it is zeroed by the sweep, which keeps
  // it mappable to plain storage without a per-bit reset net.
  always_ff @(posedge clk) begin
    if (busy_o) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_ok[w]) begin
          mem_q[wr_addr_i[w]] <= wr_data_i[w];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NUM_RD); r++) begin
      stored[r] = '0;
      rd_ok[r]  = 1'b0;
      if ({1'b0, rd_addr_i[r]} < DEPTH_L) begin
        stored[r] = mem_q[rd_addr_i[r]];
        rd_ok[r]  = !busy_o;
      end
    end
  end

  for (genvar r = 0; r < int'(NUM_RD); r++) begin : g_rd
    ram_bypass_mux #(
      .INDEX  (INDEX),
      .WIDTH  (WIDTH),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) u_mux (
      .rd_addr_i  (rd_addr_i[r]),
      .rd_valid_i (rd_ok[r]),
      .stored_i   (stored[r]),
      .wr_ok_i    (wr_ok),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .rd_data_o  (rd_data_o[r])
    );
  end

endmodule

// File: tb/tb_ram_multiport_clr.sv
// Directed bench for ram_multiport_clr: reset sweep, forwarding, collisions,
// bulk clear, mid-sweep reset, and a DEPTH=12 build with out-of-range addresses.
module tb_ram_multiport_clr;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_i;
  logic [3:0][3:0] rd_addr;
  logic [1:0][3:0] wr_addr;
  logic [1:0]      we;
  logic [1:0][7:0] wr_data;
  logic [3:0][7:0] rd_data, rd_data12;
  logic            busy, busy12, conflict, conflict12;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_multiport_clr dut (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (clear_i),
    .rd_addr_i     (rd_addr),
    .wr_addr_i     (wr_addr),
    .we_i          (we),
    .wr_data_i     (wr_data),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .wr_conflict_o (conflict)
  );

  ram_multiport_clr #(.DEPTH(12), .INDEX(4)) dut12 (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (clear_i),
    .rd_addr_i     (rd_addr),
    .wr_addr_i     (wr_addr),
    .we_i          (we),
    .wr_data_i     (wr_data),
    .rd_data_o     (rd_data12),
    .busy_o        (busy12),
    .wr_conflict_o (conflict12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_i = 1'b0;
    we      = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_async: got %b expected 1", busy);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rd_data[r] !== 8'h00) begin
        failures++;
        $display("FAIL reset_rd_async[%0d]: got %h expected 00", r, rd_data[r]);
      end
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (busy !== (k < 16)) begin
        failures++;
        $display("FAIL reset_sweep_busy edge %0d: got %b expected %b", k, busy, k < 16);
      end
      checks++;
      if (busy12 !== (k < 12)) begin
        failures++;
        $display("FAIL reset_sweep_busy12 edge %0d: got %b expected %b", k, busy12, k < 12);
      end
    end
    for (int g = 0; g < 4; g++) begin
      for (int r = 0; r < 4; r++) rd_addr[r] = 4'(g * 4 + r);
      #1;
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (rd_data[r] !== 8'h00) begin
          failures++;
          $display("FAIL reset_swept addr %0d: got %h expected 00", g * 4 + r, rd_data[r]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    tick();
    idle_inputs();
    we[0]      = 1'b1;
    wr_addr[0] = 4'd3;
    wr_data[0] = 8'hA5;
    rd_addr[0] = 4'd3;
    #1;
    checks++;
    if (rd_data[0] !== 8'hA5) begin
      failures++;
      $display("FAIL bypass_same_cycle: got %h expected a5", rd_data[0]);
    end
    tick();
    idle_inputs();
    for (int r = 0; r < 4; r++) rd_addr[r] = 4'd3;
    #1;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rd_data[r] !== 8'hA5) begin
        failures++;
        $display("FAIL bypass_stored port %0d: got %h expected a5", r, rd_data[r]);
      end
    end
  endtask

  task automatic test_conflict();
    tick();
    idle_inputs();
    we         = 2'b11;
    wr_addr[0] = 4'd7;
    wr_addr[1] = 4'd7;
    wr_data[0] = 8'h11;
    wr_data[1] = 8'h22;
    rd_addr[0] = 4'd7;
    #1;
    checks++;
    if (rd_data[0] !== 8'h22) begin
      failures++;
      $display("FAIL conflict_fwd_priority: got %h expected 22", rd_data[0]);
    end
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_before: got %b expected 0", conflict);
    end
    tick();
    idle_inputs();
    rd_addr[0] = 4'd7;
    #1;
    checks++;
    if (conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_flag: got %b expected 1", conflict);
    end
    checks++;
    if (rd_data[0] !== 8'h22) begin
      failures++;
      $display("FAIL conflict_stored: got %h expected 22", rd_data[0]);
    end
    // Distinct addresses on both ports must not raise the flag.
    tick();
    we         = 2'b11;
    wr_addr[0] = 4'd8;
    wr_addr[1] = 4'd9;
    wr_data[0] = 8'h08;
    wr_data[1] = 8'h09;
    #1;
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_one_cycle: got %b expected 0", conflict);
    end
    tick();
    idle_inputs();
    rd_addr[0] = 4'd8;
    rd_addr[1] = 4'd9;
    #1;
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_distinct: got %b expected 0", conflict);
    end
    checks++;
    if (rd_data[1:0] !== 16'h0908) begin
      failures++;
      $display("FAIL dual_write_readback: got %h expected 0908", rd_data[1:0]);
    end
  endtask

  task automatic test_clear();
    tick();
    idle_inputs();
    clear_i    = 1'b1;
    we[0]      = 1'b1;
    wr_addr[0] = 4'd2;
    wr_data[0] = 8'h5A;
    rd_addr[0] = 4'd2;
    rd_addr[1] = 4'd3;
    #1;
    checks++;
    if (rd_data[0] !== 8'h00) begin
      failures++;
      $display("FAIL clear_no_fwd: got %h expected 00", rd_data[0]);
    end
    checks++;
    if (rd_data[1] !== 8'hA5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_pre_state: got rd=%h busy=%b expected rd=a5 busy=0", rd_data[1], busy);
    end
    for (int k = 0; k <= 16; k++) begin
      tick();
      idle_inputs();
      clear_i = (k < 9);
      if (k >= 2 && k <= 13) begin
        we         = 2'b11;
        wr_addr[0] = 4'd2;
        wr_data[0] = 8'h5A;
        wr_addr[1] = 4'd15;
        wr_data[1] = 8'h77;
        rd_addr[0] = 4'd2;
      end
      #1;
      checks++;
      if (busy !== (k < 16)) begin
        failures++;
        $display("FAIL clear_busy edge %0d: got %b expected %b", k, busy, k < 16);
      end
      if (k == 5) begin
        checks++;
        if (rd_data[0] !== 8'h00) begin
          failures++;
          $display("FAIL clear_busy_read: got %h expected 00", rd_data[0]);
        end
      end
    end
    rd_addr[0] = 4'd2;
    rd_addr[1] = 4'd3;
    rd_addr[2] = 4'd7;
    rd_addr[3] = 4'd15;
    #1;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rd_data[r] !== 8'h00) begin
        failures++;
        $display("FAIL clear_result port %0d addr %0d: got %h expected 00", r, rd_addr[r], rd_data[r]);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    tick();
    idle_inputs();
    clear_i = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      clear_i = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL midsweep_reset: got busy=%b rd=%h expected busy=1 rd=0", busy, rd_data);
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (busy !== (k < 16)) begin
        failures++;
        $display("FAIL midsweep_restart edge %0d: got %b expected %b", k, busy, k < 16);
      end
    end
    we[1]      = 1'b1;
    wr_addr[1] = 4'd4;
    wr_data[1] = 8'h3C;
    tick();
    idle_inputs();
    rd_addr[2] = 4'd4;
    #1;
    checks++;
    if (rd_data[2] !== 8'h3C) begin
      failures++;
      $display("FAIL post_reset_write: got %h expected 3c", rd_data[2]);
    end
  endtask

  task automatic test_depth12();
    tick();
    idle_inputs();
    we         = 2'b11;
    wr_addr[0] = 4'd13;
    wr_data[0] = 8'h99;
    wr_addr[1] = 4'd11;
    wr_data[1] = 8'h4C;
    rd_addr[0] = 4'd13;
    rd_addr[1] = 4'd11;
    #1;
    checks++;
    if (rd_data12[0] !== 8'h00) begin
      failures++;
      $display("FAIL d12_oob_fwd: got %h expected 00", rd_data12[0]);
    end
    checks++;
    if (rd_data12[1] !== 8'h4C) begin
      failures++;
      $display("FAIL d12_last_fwd: got %h expected 4c", rd_data12[1]);
    end
    tick();
    idle_inputs();
    we         = 2'b11;
    wr_addr[0] = 4'd13;
    wr_data[0] = 8'h55;
    wr_addr[1] = 4'd13;
    wr_data[1] = 8'h66;
    rd_addr[0] = 4'd13;
    rd_addr[1] = 4'd11;
    #1;
    checks++;
    if (rd_data12[0] !== 8'h00 || rd_data12[1] !== 8'h4C) begin
      failures++;
      $display("FAIL d12_stored: got %h/%h expected 00/4c", rd_data12[0], rd_data12[1]);
    end
    tick();
    idle_inputs();
    rd_addr[0] = 4'd13;
    #1;
    checks++;
    if (conflict12 !== 1'b0) begin
      failures++;
      $display("FAIL d12_oob_conflict: got %b expected 0", conflict12);
    end
    checks++;
    if (rd_data12[0] !== 8'h00) begin
      failures++;
      $display("FAIL d12_oob_read: got %h expected 00", rd_data12[0]);
    end
    checks++;
    if (conflict !== 1'b1 || rd_data[0] !== 8'h66) begin
      failures++;
      $display("FAIL d16_in_range_13: got conflict=%b rd=%h expected 1/66", conflict, rd_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_clear();
    test_reset_midsweep();
    test_depth12();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_multiport_clr.md
RAM_MULTIPORT_CLR -- requirements
Module: ram_multiport_clr

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 16, number of entries.
- INDEX, 4, address width; DEPTH ≤ 2^INDEX.
- WIDTH, 8, data width.
- NUM_RD, 4, read ports.
- NUM_WR, 2, write ports.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write contents.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on posedge.
- reset, in, 1, asynchronous, active-high.
- clear_i, in, 1, request a bulk clear of the array.
- rd_addr_i, in, NUM_RD x INDEX, read addresses.
- wr_addr_i, in, NUM_WR x INDEX, write addresses.
- we_i, in, NUM_WR, per-port write enable.
- wr_data_i, in, NUM_WR x WIDTH, write data.
- rd_data_o, out, NUM_RD x WIDTH, combinational read data.
- busy_o, out, 1, clear sweep in progress.
- wr_conflict_o, out, 1, registered flag: same-address write collision in the previous cycle.

Function
REQ-003 The block SHALL contain a two-state controller with states IDLE and CLEAR and an INDEX-bit sweep pointer clr_ptr.
REQ-004 In CLEAR, each cycle SHALL write 0 to entry clr_ptr and increment clr_ptr.
REQ-005 The write with clr_ptr == DEPTH-1 SHALL be the last; the controller SHALL enter IDLE on the following edge, so a sweep lasts exactly DEPTH cycles.
REQ-006 In IDLE with clear_i=1, the controller SHALL enter CLEAR with clr_ptr=0 on the next edge.
REQ-007 clear_i asserted while in CLEAR SHALL be ignored; the sweep is neither restarted nor extended.
REQ-008 busy_o SHALL equal (state == CLEAR).
REQ-009 Port w SHALL write wr_data_i[w] to entry wr_addr_i[w] on the edge when all of the following hold: we_i[w]=1, busy_o=0, clear_i=0, and wr_addr_i[w] < DEPTH. Otherwise the write SHALL be dropped silently.
REQ-010 When several accepted writes target the same address, the highest-numbered port SHALL win.
REQ-011 wr_conflict_o SHALL be 1 for exactly the cycle after a cycle in which two or more accepted writes shared an address, and 0 otherwise.
REQ-012 rd_data_o[r] SHALL be 0 when busy_o=1 or rd_addr_i[r] >= DEPTH. Otherwise it SHALL be the stored entry, with zero-cycle latency.
REQ-013 With BYPASS=1, rd_data_o[r] SHALL forward the data of the winning accepted write to the same address in the same cycle (REQ-010 priority). With BYPASS=0, no forwarding SHALL occur.
REQ-014 Any number of read ports SHALL be allowed to read the same address concurrently, with identical results.

Reset
REQ-015 reset asserted SHALL immediately force state=CLEAR, clr_ptr=0 and wr_conflict_o=0.
REQ-016 During reset, busy_o=1 and every rd_data_o=0, independent of clk.
REQ-017 After reset deasserts, the array SHALL be swept (REQ-004/005) and busy_o SHALL fall DEPTH edges later.
REQ-018 Storage SHALL NOT be asynchronously reset; it is zeroed only by the sweep.
REQ-019 Reset asserted mid-sweep SHALL restart the sweep from entry 0.

Structure
REQ-020 A shared package ram_pkg SHALL hold the controller state enum (IDLE, CLEAR) and a clog2-based index-width helper constant.
REQ-021 Per-read-port forwarding and priority selection SHALL be one sub-module, ram_bypass_mux, instantiated NUM_RD times.
REQ-022 The controller, sweep pointer, conflict flag and array SHALL reside in ram_multiport_clr.

Verification
All scenarios use the defaults DEPTH=16, WIDTH=8, NUM_RD=4, NUM_WR=2, BYPASS=1.
REQ-023 Reset pulse, then hold inputs quiet -> busy_o=1 for 16 edges then 0; all reads of addresses 0..15 return 0x00.
REQ-024 Write port0 addr 3 data 0xA5 with rd_addr_i[0]=3 in the same cycle -> rd_data_o[0]=0xA5 that cycle; next cycle rd_addr_i[1]=3 also returns 0xA5.
REQ-025 Port0 writes addr 7 data 0x11 and port1 writes addr 7 data 0x22 in the same cycle -> the same-cycle read of addr 7 returns 0x22; wr_conflict_o=1 next cycle only; a later read of addr 7 returns 0x22.
REQ-026 clear_i=1 together with port0 write addr 2 data 0x5A -> write dropped; busy_o=1 for 16 cycles; writes during the sweep are dropped; afterwards addr 2 reads 0x00.
REQ-027 Reset asserted at sweep cycle 9 -> busy_o stays 1, clr_ptr restarts at 0, and busy_o falls 16 edges after reset release.
REQ-028 Rebuild with DEPTH=12 (INDEX=4): write to addr 13 -> dropped; read of addr 13 -> 0x00; addrs 0..11 behave normally.
